// File: rtl/bitmap_rom_fetcher.sv
// bitmap_rom_fetcher: walks a W x H window of a 1-cycle-latency bitmap ROM in raster order into a valid/ready pixel stream.
// Latency: start to first rom_addr_o 1 clk, to first pix_valid_o 3 clk; one pixel per clk afterwards with ready held high.
// Backpressure: ROM reads are issued only against free output-buffer credit; pix_valid_o holds its pixel until accepted.
// Optional macro BITMAP_COLOR_EXPAND_EN: adds fg/bg colour inputs and emits 16-bit colour pixels instead of raw ROM words.

// bitmap_rom_fetcher_fifo: small synchronous FIFO with single-cycle flush; head entry visible on o_dat.
// Latency: a pushed entry is visible on o_dat the cycle after the push.
// Backpressure: none internally; the writer keeps o_count plus outstanding writes within DEPTH.
module bitmap_rom_fetcher_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage array: no reset needed, the occupancy count decides what is visible.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointer and occupancy tracking; flush discards every entry in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

module bitmap_rom_fetcher #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 1,
  parameter int DIM_WIDTH  = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [DIM_WIDTH-1:0]  width_i,
  input  logic [DIM_WIDTH-1:0]  height_i,
`ifdef BITMAP_COLOR_EXPAND_EN
  input  logic [15:0]           fg_color_i,
  input  logic [15:0]           bg_color_i,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
`ifdef BITMAP_COLOR_EXPAND_EN
  output logic [15:0]           pix_data_o,
`else
  output logic [DATA_WIDTH-1:0] pix_data_o,
`endif
  output logic                  pix_eol_o,
  output logic                  pix_eof_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched command and raster position of the next read to issue.
  logic [DIM_WIDTH-1:0]  r_width;
  logic [DIM_WIDTH-1:0]  r_height;
  logic [DIM_WIDTH-1:0]  r_col;
  logic [DIM_WIDTH-1:0]  r_row;
  logic [ADDR_WIDTH-1:0] r_addr_nxt;

  // Read pipeline: stage 1 = address on the ROM bus, stage 2 = ROM data valid this cycle.
  logic r_s1_vld, r_s1_eol, r_s1_eof;
  logic r_s2_vld, r_s2_eol, r_s2_eof;

  logic               w_accept;
  logic               w_issue;
  logic               w_flush;
  logic               w_push;
  logic               w_pop;
  logic               w_col_last;
  logic               w_row_last;
  logic               w_last_issue;
  logic               w_credit_ok;
  logic               w_drained;
  logic [CNT_W:0]     w_used;
  logic [CNT_W-1:0]   w_fifo_count;
  logic [ENTRY_W-1:0] w_fifo_dat;
  logic [ENTRY_W-1:0] w_push_dat;

  assign w_col_last   = (r_col == r_width - DIM_WIDTH'(1));
  assign w_row_last   = (r_row == r_height - DIM_WIDTH'(1));
  assign w_last_issue = w_col_last && w_row_last;

  // Credit counts buffered entries plus reads still in the ROM pipe, minus a pop this cycle.
  assign w_used      = {1'b0, w_fifo_count} + (CNT_W+1)'(r_s1_vld) + (CNT_W+1)'(r_s2_vld)
                       - (CNT_W+1)'(w_pop);
  assign w_credit_ok = (w_used < (CNT_W+1)'(FIFO_DEPTH));

  // Frame is finished once nothing is in the pipe and the buffer empties (or its last entry leaves now).
  assign w_drained = !r_s1_vld && !r_s2_vld &&
                     ((w_fifo_count == '0) || ((w_fifo_count == CNT_W'(1)) && w_pop));

  assign w_flush = abort_i && (r_state != S_IDLE);

  // Next-state and per-cycle control; abort overrides everything outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ((width_i == '0) || (height_i == '0)) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_last_issue) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_drained) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command capture and raster walk: address, column and row advance once per issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width    <= '0;
      r_height   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_addr_nxt <= '0;
      rom_addr_o <= '0;
    end else if (w_accept) begin
      r_width    <= width_i;
      r_height   <= height_i;
      r_col      <= '0;
      r_row      <= '0;
      r_addr_nxt <= base_i;
    end else if (w_issue) begin
      rom_addr_o <= r_addr_nxt;
      r_addr_nxt <= r_addr_nxt + ADDR_WIDTH'(1);
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + DIM_WIDTH'(1);
      end else begin
        r_col <= r_col + DIM_WIDTH'(1);
      end
    end
  end

  // Line/frame markers travel alongside each read so they land in the buffer with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_eol <= 1'b0;
      r_s1_eof <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_eol <= 1'b0;
      r_s2_eof <= 1'b0;
    end else if (w_flush) begin
      r_s1_vld <= 1'b0;
      r_s1_eol <= 1'b0;
      r_s1_eof <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_eol <= 1'b0;
      r_s2_eof <= 1'b0;
    end else begin
      r_s1_vld <= w_issue;
      r_s1_eol <= w_issue && w_col_last;
      r_s1_eof <= w_issue && w_last_issue;
      r_s2_vld <= r_s1_vld;
      r_s2_eol <= r_s1_eol;
      r_s2_eof <= r_s1_eof;
    end
  end

  assign w_push     = r_s2_vld && !w_flush;
  assign w_push_dat = {r_s2_eof, r_s2_eol, rom_data_i};
  assign w_pop      = pix_valid_o && pix_ready_i;

  bitmap_rom_fetcher_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_dat),
    .o_count (w_fifo_count)
  );

  assign pix_valid_o = (w_fifo_count != '0);
  assign pix_eol_o   = pix_valid_o && w_fifo_dat[DATA_WIDTH];
  assign pix_eof_o   = pix_valid_o && w_fifo_dat[DATA_WIDTH+1];
  assign busy_o      = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign done_o      = (r_state == S_DONE);

`ifdef BITMAP_COLOR_EXPAND_EN
  logic [15:0] r_fg;
  logic [15:0] r_bg;

  // Colours are frame attributes, captured together with the command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fg <= '0;
      r_bg <= '0;
    end else if (w_accept) begin
      r_fg <= fg_color_i;
      r_bg <= bg_color_i;
    end
  end

  assign pix_data_o = !pix_valid_o ? 16'h0000 : (w_fifo_dat[0] ? r_fg : r_bg);
`else
  assign pix_data_o = pix_valid_o ? w_fifo_dat[DATA_WIDTH-1:0] : '0;
`endif

endmodule

// File: tb/tb_bitmap_rom_fetcher.sv
`timescale 1ns/1ps
module tb_bitmap_rom_fetcher;

  localparam int AW  = 17;
  localparam int DW  = 1;
  localparam int DMW = 9;
  localparam int FD  = 4;
`ifdef BITMAP_COLOR_EXPAND_EN
  localparam int PW = 16;
`else
  localparam int PW = DW;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic [AW-1:0]  base_i = '0;
  logic [DMW-1:0] width_i = '0;
  logic [DMW-1:0] height_i = '0;
`ifdef BITMAP_COLOR_EXPAND_EN
  logic [15:0]    fg_color_i = 16'hF800;
  logic [15:0]    bg_color_i = 16'h001F;
`endif
  logic [AW-1:0]  rom_addr_o;
  logic [DW-1:0]  rom_data_i;
  logic           pix_valid_o;
  logic           pix_ready_i = 1'b0;
  logic [PW-1:0]  pix_data_o;
  logic           pix_eol_o;
  logic           pix_eof_o;
  logic           busy_o;
  logic           done_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rom_key = 32'h1234_5678;

  always #5 clk = ~clk;

  bitmap_rom_fetcher #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DIM_WIDTH  (DMW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_i      (base_i),
    .width_i     (width_i),
    .height_i    (height_i),
`ifdef BITMAP_COLOR_EXPAND_EN
    .fg_color_i  (fg_color_i),
    .bg_color_i  (bg_color_i),
`endif
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .pix_valid_o (pix_valid_o),
    .pix_ready_i (pix_ready_i),
    .pix_data_o  (pix_data_o),
    .pix_eol_o   (pix_eol_o),
    .pix_eof_o   (pix_eof_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // Bitmap contents: a keyed hash of the address.
  function automatic logic rom_bit(input logic [AW-1:0] a);
    logic [31:0] hv;
    hv = ({15'd0, a} ^ rom_key) * 32'h045D_9F3B;
    return hv[20];
  endfunction

  function automatic logic [PW-1:0] exp_pix(input logic b);
`ifdef BITMAP_COLOR_EXPAND_EN
    return b ? 16'hF800 : 16'h001F;
`else
    return PW'(b);
`endif
  endfunction

  // Registered-read ROM.
  always @(posedge clk) rom_data_i <= rom_bit(rom_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One command: builds the expected raster stream, then watches the outputs cycle by cycle.
  task automatic run_frame(input logic [AW-1:0] base, input int w, input int h, input int rdy_pct,
                           input bit timing, input int abort_cyc, input bit busy_start);
    logic [PW+1:0] exp_q[$];
    logic [PW+1:0] got;
    logic [PW+1:0] prev;
    logic [AW-1:0] ea;
    int n, first_v, last_hs, done_cyc, dones, got_n;
    bit stall, abort_seen;
    n = w * h;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        ea = base + AW'(r * w + c);
        exp_q.push_back({(c == w - 1) && (r == h - 1), c == w - 1, exp_pix(rom_bit(ea))});
      end
    end
    @(posedge clk); #1;
    start_i = 1'b1; base_i = base; width_i = DMW'(w); height_i = DMW'(h);
    @(posedge clk); #1;
    start_i = 1'b0;
    first_v = -1; last_hs = -1; done_cyc = -1; dones = 0; got_n = 0;
    stall = 1'b0; abort_seen = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pix_ready_i = ($urandom_range(99) < rdy_pct);
      if (busy_start) begin
        start_i = (cyc == 1);
        if (cyc == 1) begin base_i = 17'h01234; width_i = 9'd3; height_i = 9'd3; end
      end
      abort_i = (cyc == abort_cyc);
      @(negedge clk);
      got = {pix_eof_o, pix_eol_o, pix_data_o};
      if (stall && !abort_seen) begin
        check("hold_valid", pix_valid_o, 1);
        check("hold_data", got, prev);
      end
      if (timing && cyc >= 1 && cyc <= n) begin
        ea = base + AW'(cyc - 1);
        check("rom_addr", rom_addr_o, ea);
      end
      if (cyc == 0) check("busy_after_start", busy_o, n != 0);
      if (abort_seen) check("abort_quiet", {pix_valid_o, busy_o, done_o}, 0);
      if (pix_valid_o && first_v < 0) first_v = cyc;
      if (pix_valid_o && pix_ready_i) begin
        if (exp_q.size() == 0) check("extra_pixel", got_n + 1, n);
        else check("pixel", got, exp_q.pop_front());
        got_n++;
        last_hs = cyc;
      end
      stall = pix_valid_o && !pix_ready_i;
      prev = got;
      if (done_o) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == abort_cyc) abort_seen = 1'b1;
      @(posedge clk); #1;
      if (abort_cyc >= 0 && cyc >= abort_cyc + 10) break;
      if (abort_cyc < 0 && done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    abort_i = 1'b0; start_i = 1'b0; pix_ready_i = 1'b0;
    if (abort_cyc < 0) begin
      check("done_count", dones, 1);
      check("pixel_count", got_n, n);
      if (timing) begin
        check("first_valid_cycle", first_v, (n != 0) ? 3 : -1);
        check("last_handshake_cycle", last_hs, (n != 0) ? n + 2 : -1);
        check("done_cycle", done_cyc, (n != 0) ? n + 3 : 0);
      end
    end else begin
      check("abort_no_done", dones, 0);
    end
  endtask

  initial begin
    rom_key = $urandom;
    #3;
    check("reset_addr", rom_addr_o, 0);
    check("reset_flags", {pix_valid_o, pix_eol_o, pix_eof_o, busy_o, done_o}, 0);
    check("reset_data", pix_data_o, 0);
    #9 rst_n = 1'b1;

    run_frame(17'h00100, 4, 2, 100, 1'b1, -1, 1'b0);
    run_frame(17'h00100, 4, 2, 30, 1'b0, -1, 1'b1);
    run_frame(17'h1FFFE, 4, 1, 100, 1'b1, -1, 1'b0);
    run_frame(17'h00040, 0, 5, 100, 1'b1, -1, 1'b0);
    run_frame(17'h00777, 1, 1, 100, 1'b1, -1, 1'b0);
    run_frame(17'h00900, 1, 3, 60, 1'b0, -1, 1'b0);
    run_frame(AW'($urandom), 4, 4, 0, 1'b0, 5, 1'b0);
    run_frame(AW'($urandom), 4, 4, 50, 1'b0, -1, 1'b0);

    // Asynchronous reset in the middle of a running frame.
    @(posedge clk); #1;
    start_i = 1'b1; base_i = 17'h00ABC; width_i = 9'd5; height_i = 9'd3;
    @(posedge clk); #1;
    start_i = 1'b0; pix_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_addr", rom_addr_o, 0);
    check("midframe_reset_flags", {pix_valid_o, pix_eol_o, pix_eof_o, busy_o, done_o}, 0);
    check("midframe_reset_data", pix_data_o, 0);
    pix_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_frame(AW'($urandom), $urandom_range(1, 6), $urandom_range(1, 4),
                $urandom_range(20, 90), 1'b0, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
